// File: rtl/pc_fetch_if.sv
// Fetch-unit bus: instruction-memory request/return, redirect input and the ID-side handshake.
// The trap signals (exc_req/epc) exist only when PC_TRAP_EN is defined.
interface pc_fetch_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              id_valid;
    logic              id_ready;
    logic [ADDR_W-1:0] id_pc;
    logic [DATA_W-1:0] id_instr;
`ifdef PC_TRAP_EN
    logic              exc_req;
    logic [ADDR_W-1:0] epc;
`endif

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata,
        input  redirect_valid, redirect_pc,
        output id_valid, id_pc, id_instr,
        input  id_ready
`ifdef PC_TRAP_EN
        , input exc_req
        , output epc
`endif
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata,
        output redirect_valid, redirect_pc,
        input  id_valid, id_pc, id_instr,
        output id_ready
`ifdef PC_TRAP_EN
        , output exc_req
        , input epc
`endif
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// IF-stage program counter plus fetch buffer: issues word fetches, queues {pc, instr} pairs for ID.
// Define PC_TRAP_EN to add exception redirect to EXC_VECTOR with epc capture.
module pc_fetch_unit #(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter logic [ADDR_W-1:0] INC        = ADDR_W'(1),
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int unsigned       DEPTH      = 2,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(32'h80)
) (
    input logic        clk,
    input logic        rst_n,
    pc_fetch_if.master bus
);
    localparam int unsigned    PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned    CNT_W     = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    entry_t            mem [DEPTH];
    entry_t            head;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] pc, inflight_pc, flush_pc;
    logic              inflight, flush, issue, push, pop, id_valid;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

`ifdef PC_TRAP_EN
    logic [ADDR_W-1:0] epc;

    assign flush    = bus.exc_req || bus.redirect_valid;
    assign flush_pc = bus.exc_req ? EXC_VECTOR : bus.redirect_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           epc <= '0;
        else if (bus.exc_req) epc <= id_valid ? head.pc : pc;
    end

    assign bus.epc = epc;
`else
    logic unused_exc_vector;

    assign unused_exc_vector = ^EXC_VECTOR;
    assign flush             = bus.redirect_valid;
    assign flush_pc          = bus.redirect_pc;
`endif

    assign head     = mem[rd_ptr];
    assign id_valid = (count != '0);
    assign pop      = id_valid && bus.id_ready;
    // A return is dropped on a flush edge: its slot belongs to the old, discarded path.
    assign push     = inflight && !flush;
    // Gating with rst_n keeps imem_req low for the whole reset window, not only after an edge.
    assign issue    = rst_n && !flush
                    && (({1'b0, count} + (CNT_W + 1)'(inflight)) < DEPTH_LIM);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            inflight <= issue;
            if (issue) inflight_pc <= pc;
            if (flush) begin
                pc     <= flush_pc;
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (issue) pc     <= pc + INC;
                if (push)  wr_ptr <= ptr_next(wr_ptr);
                if (pop)   rd_ptr <= ptr_next(rd_ptr);
                if (push && !pop)      count <= count + CNT_W'(1);
                else if (pop && !push) count <= count - CNT_W'(1);
            end
        end
    end

    // NOTE: the buffer storage has no reset; count gates every read, so stale entries are never seen.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {inflight_pc, bus.imem_rdata};
    end

    assign bus.imem_req  = issue;
    assign bus.imem_addr = pc;
    assign bus.id_valid  = id_valid;
    assign bus.id_pc     = id_valid ? head.pc    : '0;
    assign bus.id_instr  = id_valid ? head.instr : '0;
endmodule
